// File: rtl/mcycle_cpu_if.sv
// rtl/mcycle_cpu_if.sv - instruction and data memory bus bundle for mcycle_cpu
interface mcycle_cpu_if #(
    parameter int PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rdy;
    logic [31:0]     imem_data;
    logic            dmem_req;
    logic            dmem_we;
    logic [PC_W-1:0] dmem_addr;
    logic [31:0]     dmem_wdata;
    logic            dmem_rdy;
    logic [31:0]     dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdy, imem_data,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdy, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdy, imem_data,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdy, dmem_rdata
    );
endinterface

// File: rtl/mcycle_cpu.sv
// rtl/mcycle_cpu.sv - multi-cycle MIPS subset CPU (FETCH/DECODE/EXEC/MEM/WB)
module mcycle_cpu #(
    parameter int          PC_W     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREG     = 32
) (
    input  logic            Clk,
    input  logic            Clrn,
    mcycle_cpu_if.master    bus,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      state,
    output logic            halted
);
    localparam int IW = $clog2(NREG);
    localparam logic [PC_W-1:0] RST_PC = RESET_PC[PC_W-1:0];

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [31:0]     alu_q, alu_d;
    logic [31:0]     mdr_q, mdr_d;
    logic [31:0]     rf_q [NREG];
    logic            imem_req_q, dmem_req_q, dmem_we_q, halted_q;

    logic            rf_we;
    logic [IW-1:0]   rf_wa;
    logic [31:0]     rf_wd;

    logic [5:0]      op, funct;
    logic [IW-1:0]   rs_idx, rt_idx, rd_idx;
    logic [31:0]     sext, zext, br_off, pc_ext, jt;
    logic            op_valid;
    logic            unused_bits;

    assign op     = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign rs_idx = ir_q[21 +: IW];
    assign rt_idx = ir_q[16 +: IW];
    assign rd_idx = ir_q[11 +: IW];
    assign sext   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign zext   = {16'h0000, ir_q[15:0]};
    assign br_off = {sext[29:0], 2'b00};
    assign pc_ext = 32'(pc_q);
    // For PC_W <= 28 the upper pc bits fall away in the final truncation.
    assign jt     = {pc_ext[31:28], ir_q[25:0], 2'b00};
    assign unused_bits = ^{ir_q, alu_q, pc_ext, jt};

    always_comb begin
        op_valid = 1'b0;
        case (op)
            OP_R:    op_valid = (funct == FN_ADD) || (funct == FN_SUB) ||
                                (funct == FN_AND) || (funct == FN_OR);
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J: op_valid = 1'b1;
            default: op_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        rf_we   = 1'b0;
        rf_wa   = rt_idx;
        rf_wd   = alu_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_rdy) begin
                    ir_d    = bus.imem_data;
                    pc_d    = pc_q + PC_W'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rs_idx];
                b_d     = rf_q[rt_idx];
                state_d = op_valid ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                state_d = S_WB;
                case (op)
                    OP_R: begin
                        case (funct)
                            FN_ADD:  alu_d = a_q + b_q;
                            FN_SUB:  alu_d = a_q - b_q;
                            FN_AND:  alu_d = a_q & b_q;
                            default: alu_d = a_q | b_q;
                        endcase
                    end
                    OP_ADDI: alu_d = a_q + sext;
                    OP_ANDI: alu_d = a_q & zext;
                    OP_ORI:  alu_d = a_q | zext;
                    OP_LW, OP_SW: begin
                        alu_d   = a_q + sext;
                        state_d = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        if ((a_q == b_q) == (op == OP_BEQ))
                            pc_d = pc_q + br_off[PC_W-1:0];
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_d    = jt[PC_W-1:0];
                        state_d = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_rdy) begin
                    if (op == OP_LW) begin
                        mdr_d   = bus.dmem_rdata;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wa   = (op == OP_R) ? rd_idx : rt_idx;
                rf_wd   = (op == OP_LW) ? mdr_q : alu_q;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state_q    <= S_FETCH;
            pc_q       <= RST_PC;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_q      <= '0;
            mdr_q      <= '0;
            imem_req_q <= 1'b1;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            halted_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            alu_q      <= alu_d;
            mdr_q      <= mdr_d;
            imem_req_q <= (state_d == S_FETCH);
            dmem_req_q <= (state_d == S_MEM);
            dmem_we_q  <= (state_d == S_MEM) && (op == OP_SW);
            halted_q   <= (state_d == S_HALT);
            // Register 0 is never written, so it stays at its reset value of zero.
            if (rf_we && (rf_wa != '0)) rf_q[rf_wa] <= rf_wd;
        end
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = alu_q[PC_W-1:0];
    assign bus.dmem_wdata = b_q;
    assign pc             = pc_q;
    assign state          = state_q;
    assign halted         = halted_q;
endmodule

// File: tb/tb_mcycle_cpu.sv
// tb/tb_mcycle_cpu.sv - directed vector bench for mcycle_cpu
module tb_mcycle_cpu;
    logic        Clk = 1'b0;
    logic        Clrn;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        halted;

    mcycle_cpu_if #(.PC_W(32)) bus ();

    mcycle_cpu #(.PC_W(32), .RESET_PC(32'h0), .NREG(32)) dut (
        .Clk    (Clk),
        .Clrn   (Clrn),
        .bus    (bus.master),
        .pc     (pc),
        .state  (state),
        .halted (halted)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] instr;
        int          dwait;
        logic [31:0] rdata;
        int          cyc;
        int          ridx;
        logic [31:0] rval;
        logic [31:0] pcv;
        int          reqc;
        int          wec;
        logic [31:0] daddr;
        logic [31:0] wdata;
    } vec_t;

    vec_t        tv [17];
    int          n_checks = 0;
    int          n_fail = 0;
    int          req_cyc, we_cyc;
    logic [31:0] last_daddr, last_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exec_one(input logic [31:0] instr, input int dwait,
                            input logic [31:0] rdata, output int cyc);
        int dcnt = 0;
        cyc = 0;
        req_cyc = 0;
        we_cyc = 0;
        last_daddr = '0;
        last_wdata = '0;
        bus.imem_data  = instr;
        bus.imem_rdy   = 1'b1;
        bus.dmem_rdy   = 1'b0;
        bus.dmem_rdata = rdata;
        forever begin
            @(posedge Clk);
            #1;
            cyc++;
            if (bus.dmem_req) begin
                req_cyc++;
                if (bus.dmem_we) we_cyc++;
                last_daddr   = bus.dmem_addr;
                last_wdata   = bus.dmem_wdata;
                bus.dmem_rdy = (dcnt >= dwait);
                dcnt++;
            end else begin
                bus.dmem_rdy = 1'b0;
            end
            if (state == 3'd0 || state == 3'd5 || cyc >= 50) break;
        end
    endtask

    task automatic do_reset();
        Clrn = 1'b0;
        @(posedge Clk);
        #1;
        Clrn = 1'b1;
    endtask

    initial begin
        int cyc;
        int k;
        //          instr         dw rdata         cyc reg val           pc            rq we daddr  wdata
        tv[0]  = '{32'h20010005, 0, 32'h0,         4, 1,  32'h00000005, 32'h00000004, 0, 0, 32'h0, 32'h0};
        tv[1]  = '{32'h2002FFFD, 0, 32'h0,         4, 2,  32'hFFFFFFFD, 32'h00000008, 0, 0, 32'h0, 32'h0};
        tv[2]  = '{32'h00221820, 0, 32'h0,         4, 3,  32'h00000002, 32'h0000000C, 0, 0, 32'h0, 32'h0};
        tv[3]  = '{32'h00412022, 0, 32'h0,         4, 4,  32'hFFFFFFF8, 32'h00000010, 0, 0, 32'h0, 32'h0};
        tv[4]  = '{32'h00222824, 0, 32'h0,         4, 5,  32'h00000005, 32'h00000014, 0, 0, 32'h0, 32'h0};
        tv[5]  = '{32'h00223025, 0, 32'h0,         4, 6,  32'hFFFFFFFD, 32'h00000018, 0, 0, 32'h0, 32'h0};
        tv[6]  = '{32'h3047FF00, 0, 32'h0,         4, 7,  32'h0000FF00, 32'h0000001C, 0, 0, 32'h0, 32'h0};
        tv[7]  = '{32'h34088001, 0, 32'h0,         4, 8,  32'h00008001, 32'h00000020, 0, 0, 32'h0, 32'h0};
        tv[8]  = '{32'h20200007, 0, 32'h0,         4, 0,  32'h00000000, 32'h00000024, 0, 0, 32'h0, 32'h0};
        tv[9]  = '{32'hAC010004, 3, 32'h0,         7, 1,  32'h00000005, 32'h00000028, 4, 4, 32'h4, 32'h5};
        tv[10] = '{32'h8C2A0003, 1, 32'hDEADBEEF, 6, 10, 32'hDEADBEEF, 32'h0000002C, 2, 0, 32'h8, 32'h0};
        tv[11] = '{32'h1021FFFF, 0, 32'h0,         3, 1,  32'h00000005, 32'h0000002C, 0, 0, 32'h0, 32'h0};
        tv[12] = '{32'h1421FFFF, 0, 32'h0,         3, 1,  32'h00000005, 32'h00000030, 0, 0, 32'h0, 32'h0};
        tv[13] = '{32'h14220002, 0, 32'h0,         3, 2,  32'hFFFFFFFD, 32'h0000003C, 0, 0, 32'h0, 32'h0};
        tv[14] = '{32'h10220005, 0, 32'h0,         3, 2,  32'hFFFFFFFD, 32'h00000040, 0, 0, 32'h0, 32'h0};
        tv[15] = '{32'h08000040, 0, 32'h0,         3, 1,  32'h00000005, 32'h00000100, 0, 0, 32'h0, 32'h0};
        tv[16] = '{32'h00426020, 0, 32'h0,         4, 12, 32'hFFFFFFFA, 32'h00000104, 0, 0, 32'h0, 32'h0};

        bus.imem_rdy   = 1'b0;
        bus.imem_data  = '0;
        bus.dmem_rdy   = 1'b0;
        bus.dmem_rdata = '0;
        Clrn = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Clrn = 1'b1;

        chk("rst_pc", pc, 32'h0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd1);
        chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
        chk("rst_r1", dut.rf_q[1], 32'h0);

        for (int i = 0; i < 17; i++) begin
            exec_one(tv[i].instr, tv[i].dwait, tv[i].rdata, cyc);
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(tv[i].cyc));
            chk($sformatf("v%0d_reg", i), dut.rf_q[tv[i].ridx], tv[i].rval);
            chk($sformatf("v%0d_pc", i), pc, tv[i].pcv);
            chk($sformatf("v%0d_req_cycles", i), 32'(req_cyc), 32'(tv[i].reqc));
            chk($sformatf("v%0d_we_cycles", i), 32'(we_cyc), 32'(tv[i].wec));
            if (tv[i].reqc > 0) chk($sformatf("v%0d_daddr", i), last_daddr, tv[i].daddr);
            if (tv[i].wec > 0) chk($sformatf("v%0d_wdata", i), last_wdata, tv[i].wdata);
        end

        exec_one(32'hFC000000, 0, 32'h0, cyc);
        chk("halt_cycles", 32'(cyc), 32'd2);
        chk("halt_state", 32'(state), 32'd5);
        chk("halt_flag", 32'(halted), 32'd1);
        repeat (4) @(posedge Clk);
        #1;
        chk("halt_pc_frozen", pc, 32'h00000108);
        chk("halt_state_held", 32'(state), 32'd5);
        chk("halt_imem_req", 32'(bus.imem_req), 32'd0);
        chk("halt_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("halt_r12_kept", dut.rf_q[12], 32'hFFFFFFFA);
        do_reset();
        chk("halt_rst_pc", pc, 32'h0);
        chk("halt_rst_state", 32'(state), 32'd0);
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_r1", dut.rf_q[1], 32'h0);

        bus.imem_rdy = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("iwait_state", 32'(state), 32'd0);
        chk("iwait_pc", pc, 32'h0);
        chk("iwait_imem_req", 32'(bus.imem_req), 32'd1);
        exec_one(32'h20010005, 0, 32'h0, cyc);
        chk("iwait_addi_cycles", 32'(cyc), 32'd4);
        chk("iwait_addi_r1", dut.rf_q[1], 32'h5);

        bus.imem_data  = 32'h8C230000;
        bus.imem_rdy   = 1'b1;
        bus.dmem_rdy   = 1'b0;
        bus.dmem_rdata = 32'h12345678;
        k = 0;
        while (state != 3'd3 && k < 10) begin
            @(posedge Clk);
            #1;
            k++;
        end
        chk("lwrst_in_mem", 32'(state), 32'd3);
        chk("lwrst_daddr", bus.dmem_addr, 32'h5);
        repeat (2) @(posedge Clk);
        #1;
        chk("lwrst_still_mem", 32'(state), 32'd3);
        bus.dmem_rdy = 1'b1;
        do_reset();
        bus.dmem_rdy = 1'b0;
        chk("lwrst_state", 32'(state), 32'd0);
        chk("lwrst_r3", dut.rf_q[3], 32'h0);
        chk("lwrst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("lwrst_pc", pc, 32'h0);
        repeat (2) @(posedge Clk);
        #1;
        chk("lwrst_r3_later", dut.rf_q[3], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
